spill_register_chain: RTL
=========================

// Module: spill_register_chain
// PURPOSE
//  Cascade of NUM_STAGES cut stages; each stage is a two-slot (A/B) spill stage with valid/ready.
//  Cuts every combinational path between input and output handshakes.
//  Buffers up to 2*NUM_STAGES beats and adds a synchronous flush.
//  Used on long or timing-critical stream links, e.g. between interconnect crossbars and
//  memory-side ports, where a single cut stage is not enough.
// PARAMETERS
//  T_w         1  payload width in bits (>=1)
//  NUM_STAGES  1  number of cut stages; 0 = combinational pass-through
// PORTS
//  clk_i       in   1        clock, rising edge
//  rst_ni      in   1        asynchronous reset, active low
//  flush_i     in   1        synchronous flush: discard all buffered beats
//  valid_i     in   1        upstream beat valid
//  ready_o     out  1        upstream may transfer
//  data_i      in   T_w      upstream payload
//  valid_o     out  1        downstream beat valid
//  ready_i     in   1        downstream accepts
//  data_o      out  T_w      downstream payload
//  fill_cnt_o  out  CNT_W    beats buffered; CNT_W = $clog2(2*NUM_STAGES+1), min 1
// BEHAVIOUR
//  - Clock and reset: one clock, clk_i. Reset is asynchronous, active-low on rst_ni.
//  - Reset values:
//    - All slot full flags are 0 and all slot data is 0.
//    - ready_o=1, valid_o=0, data_o=0, fill_cnt_o=0.
//  - Handshake: a transfer occurs on a cycle where valid and ready are both high.
//    - No valid-after-ready dependency.
//    - Once valid_o is high, data_o and valid_o stay stable until ready_i is high.
//  - Stage k (0 = input side):
//    - Ready for input when A or B is empty.
//    - Valid out when A or B is full.
//    - Output selects B if B is full, else A. B always holds the older beat.
//    - A fills on an input transfer.
//    - A drains when A is full and B is empty.
//    - B takes A's beat when A drains and the stage output is not accepted.
//    - B drains when B is full and the stage output is accepted.
//  - Stage k valid/ready/data connect to stage k+1. Stage 0 faces the ports; the last stage drives *_o.
//  - ready_o and valid_o depend only on flops and flush_i, never on ready_i, valid_i or data_i.
//  - Latency and throughput:
//    - Empty chain with ready_i=1: a beat accepted in cycle t gives valid_o in cycle t+NUM_STAGES.
//    - Sustained throughput is 1 beat/cycle.
//  - Capacity:
//    - With ready_i=0 the chain accepts exactly 2*NUM_STAGES beats.
//    - ready_o falls the cycle after stage 0 holds 2 beats; it may fall earlier only
//      if stage 0 is full.
//  - Ordering: beats leave in strict acceptance order. There is no loss and no duplication.
//  - Flush:
//    - While flush_i=1, ready_o=0 and valid_o=0, and no transfer occurs on either side.
//    - At the next edge all full flags clear; data flops keep their values.
//    - The next cycle is empty with ready_o=1, unless flush_i is still high.
//  - Reset mid-operation: all state clears immediately and asynchronously. In-flight beats are dropped.
//  - fill_cnt_o:
//    - Registered total of full flags.
//    - +1 on an input transfer, -1 on an output transfer.
//    - Unchanged when both happen in the same cycle. Set to 0 on flush.
//    - Never exceeds 2*NUM_STAGES; no wrap.
//  - NUM_STAGES=0:
//    - Passes through: valid_o=valid_i&~flush_i, ready_o=ready_i&~flush_i, data_o=data_i.
//    - fill_cnt_o=0.
// CONFIGURATION
//  SPILL_REGISTER_CHAIN_FILL_CNT_EN:
//   - Defined: fill_cnt_o is driven as specified.
//   - Undefined: fill_cnt_o is tied to 0 and the counter flops are not built.
//   - Handshake behaviour is identical in both cases.
// TESTING
//  - Run all scenarios at T_w=8, NUM_STAGES=3, with the macro defined.
//  - Latency: single beat 0xA5, ready_i=1 -> valid_o exactly 3 cycles later with data_o=0xA5,
//    then fill_cnt_o back to 0.
//  - Back-pressure: ready_i=0, stream 0x01..0x08 -> exactly 6 accepted, ready_o=0, fill_cnt_o=6.
//    - data_o=0x01 held stable.
//    - Then ready_i=1 -> 0x01..0x06 in order.
//  - Full throughput: valid_i=ready_i=1 for 100 cycles, counting data -> 100 beats out,
//    in order, no bubbles after the first 3 cycles.
//  - Random stall: random valid_i/ready_i at 50% for 10k cycles.
//    - Scoreboard shows no loss or reorder.
//    - fill_cnt_o equals the reference model every cycle.
//  - Flush: 4 beats buffered, flush_i pulsed 1 cycle.
//    - That cycle ready_o=0, valid_o=0.
//    - Next cycle fill_cnt_o=0, valid_o=0, ready_o=1.
//    - The next beat 0x33 emerges alone.
//  - Reset: rst_ni low mid-stream with 5 beats buffered -> valid_o=0, data_o=0, fill_cnt_o=0
//    asynchronously. Repeat with NUM_STAGES=0 pass-through and with the macro undefined
//    (fill_cnt_o=0).

Source files
------------

// File: rtl/spill_register_chain.sv
// Purpose: NUM_STAGES two-slot spill stages cutting every valid/ready/data path; SPILL_REGISTER_CHAIN_FILL_CNT_EN builds fill_cnt_o.
// Latency: NUM_STAGES cycles through an empty chain, 1 beat/cycle sustained; NUM_STAGES=0 is a combinational pass-through.
// Backpressure: ready_o comes from stage-0 flops, buffers up to 2*NUM_STAGES beats; flush_i drops them all.
module spill_register_chain #(
    parameter int unsigned T_w        = 1,
    parameter int unsigned NUM_STAGES = 1,
    localparam int unsigned CNT_W     = (NUM_STAGES == 0) ? 1 : $clog2(2 * NUM_STAGES + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [T_w-1:0]   data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [T_w-1:0]   data_o,
    output logic [CNT_W-1:0] fill_cnt_o
);

    if (NUM_STAGES == 0) begin : g_pass
        assign valid_o    = valid_i & ~flush_i;
        assign ready_o    = ready_i & ~flush_i;
        assign data_o     = data_i;
        assign fill_cnt_o = '0;
    end else begin : g_chain
        // Index k is the input side of stage k; index NUM_STAGES faces the output ports.
        logic [NUM_STAGES:0]          vld;
        logic [NUM_STAGES:0]          rdy;
        logic [NUM_STAGES:0][T_w-1:0] dat;

        assign vld[0]          = valid_i;
        assign dat[0]          = data_i;
        assign rdy[NUM_STAGES] = ready_i;
        assign ready_o         = rdy[0];
        assign valid_o         = vld[NUM_STAGES];
        assign data_o          = dat[NUM_STAGES];

        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
            logic           a_full;
            logic           b_full;
            logic [T_w-1:0] a_dat;
            logic [T_w-1:0] b_dat;
            logic           a_fill;
            logic           a_drain;
            logic           b_fill;
            logic           b_drain;

            // Handshakes are gated by flush so nothing moves during a flush cycle.
            assign rdy[k]   = ~(a_full & b_full) & ~flush_i;
            assign vld[k+1] = (a_full | b_full) & ~flush_i;
            assign dat[k+1] = b_full ? b_dat : a_dat;

            assign a_fill  = vld[k] & rdy[k];
            assign a_drain = a_full & ~b_full & ~flush_i;
            assign b_fill  = a_drain & ~rdy[k+1];
            assign b_drain = b_full & rdy[k+1];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    a_full <= 1'b0;
                    b_full <= 1'b0;
                    a_dat  <= '0;
                    b_dat  <= '0;
                end else begin
                    if (flush_i) begin
                        a_full <= 1'b0;
                        b_full <= 1'b0;
                    end else begin
                        if (a_fill) begin
                            a_full <= 1'b1;
                        end else if (a_drain) begin
                            a_full <= 1'b0;
                        end
                        if (b_fill) begin
                            b_full <= 1'b1;
                        end else if (b_drain) begin
                            b_full <= 1'b0;
                        end
                    end
                    if (a_fill) begin
                        a_dat <= dat[k];
                    end
                    if (b_fill) begin
                        b_dat <= a_dat;
                    end
                end
            end
        end

`ifdef SPILL_REGISTER_CHAIN_FILL_CNT_EN
        logic             in_xfer;
        logic             out_xfer;
        logic [CNT_W-1:0] cnt_q;

        assign in_xfer    = valid_i & rdy[0];
        assign out_xfer   = vld[NUM_STAGES] & ready_i;
        assign fill_cnt_o = cnt_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else if (flush_i) begin
                cnt_q <= '0;
            end else if (in_xfer != out_xfer) begin
                cnt_q <= in_xfer ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
            end
        end
`else
        assign fill_cnt_o = '0;
`endif
    end

endmodule
